icache_2way: RTL and testbench

Two-way set-associative instruction cache with multi-word lines, the successor to the direct-mapped single-word ICache. Sits between the instruction unit (fetch) and the memory controller. Serves combinational hits, fills a whole line on a miss as a sequence of single-word memory requests, and replaces lines by per-set LRU. Serves hits to other lines while a fill is in progress.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_way.sv | 54 +++++
 rtl/icache_2way.sv | 166 ++++++++++++++++
 tb/tb_icache_2way.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the two-way instruction cache.
package icache_pkg;

  localparam int WORD_WIDTH       = 32;
  localparam int NUM_WAYS         = 2;
  localparam int DEF_OFFSET_WIDTH = 2;
  localparam int DEF_INDEX_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } fillStateT;

  // Tag bits left above index and word offset once the byte offset is dropped.
  function automatic int tagWidth(input int indexWidth, input int offsetWidth);
    return WORD_WIDTH - 2 - indexWidth - offsetWidth;
  endfunction

  function automatic int numSets(input int indexWidth);
    return 1 << indexWidth;
  endfunction

  function automatic int lineWords(input int offsetWidth);
    return 1 << offsetWidth;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag/line storage, tag compare and word read.
module icache_way
  import icache_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH    = tagWidth(DEF_INDEX_WIDTH, DEF_OFFSET_WIDTH)
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic [INDEX_WIDTH-1:0]  rdIndex,
  input  logic [TAG_WIDTH-1:0]    rdTag,
  input  logic [OFFSET_WIDTH-1:0] rdOffset,
  output logic                    match,
  output logic                    lineValid,
  output logic [31:0]             rdData,
  input  logic [INDEX_WIDTH-1:0]  wrIndex,
  input  logic                    invEn,
  input  logic                    wordEn,
  input  logic [OFFSET_WIDTH-1:0] wrOffset,
  input  logic [31:0]             wrData,
  input  logic                    tagEn,
  input  logic [TAG_WIDTH-1:0]    wrTag
);

  localparam int SETS  = numSets(INDEX_WIDTH);
  localparam int WORDS = lineWords(OFFSET_WIDTH);

  logic [SETS-1:0]      valid;
  logic [TAG_WIDTH-1:0] tagMem  [SETS];
  logic [31:0]          dataMem [SETS][WORDS];

  always_ff @(posedge clockIn) begin
    if (resetIn)
      valid <= '0;
    else if (invEn)
      valid[wrIndex] <= 1'b0;
    else if (tagEn)
      valid[wrIndex] <= 1'b1;
  end

  // Tag and data need no reset: nothing reads them past a cleared valid bit.
  always_ff @(posedge clockIn) begin
    if (tagEn)
      tagMem[wrIndex] <= wrTag;
    if (wordEn)
      dataMem[wrIndex][wrOffset] <= wrData;
  end

  assign lineValid = valid[rdIndex];
  assign match     = lineValid && (tagMem[rdIndex] == rdTag);
  assign rdData    = dataMem[rdIndex][rdOffset];

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative I-cache: combinational hits, per-set LRU, and a
// word-at-a-time line fill that keeps serving hits while it runs.
module icache_2way
  import icache_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH    = tagWidth(INDEX_WIDTH, OFFSET_WIDTH)
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        readFlag,
  input  logic [31:0] addrIn,
  output logic        hit,
  output logic [31:0] dataOut,
  output logic        memFlag,
  output logic [31:0] addrOut,
  input  logic        validIn,
  input  logic [31:0] dataIn
);

  localparam int SETS   = numSets(INDEX_WIDTH);
  localparam int LINE_W = TAG_WIDTH + INDEX_WIDTH;
  localparam int LO     = OFFSET_WIDTH + 2;

  logic [INDEX_WIDTH-1:0]  rdIndex;
  logic [TAG_WIDTH-1:0]    rdTag;
  logic [OFFSET_WIDTH-1:0] rdOffset;
  logic                    unusedByteBits;

  assign rdOffset       = addrIn[LO-1:2];
  assign rdIndex        = addrIn[INDEX_WIDTH+LO-1:LO];
  assign rdTag          = addrIn[31:INDEX_WIDTH+LO];
  assign unusedByteBits = ^addrIn[1:0];

  fillStateT               state, stateNext;
  logic [OFFSET_WIDTH-1:0] counter, counterNext;
  logic                    memFlagNext;
  logic [31:0]             addrOutNext;
  logic                    startFill, wordWrite, fillDone;
  logic                    victim, victimSel;
  logic [LINE_W-1:0]       fillLine;
  logic [INDEX_WIDTH-1:0]  fillIndex;
  logic [TAG_WIDTH-1:0]    fillTag;
  logic [INDEX_WIDTH-1:0]  wrIndex;
  logic [SETS-1:0]         lru;

  logic [NUM_WAYS-1:0]        wayMatch;
  logic [NUM_WAYS-1:0]        wayValid;
  logic [NUM_WAYS-1:0][31:0]  wayData;

  assign fillIndex = fillLine[INDEX_WIDTH-1:0];
  assign fillTag   = fillLine[LINE_W-1:INDEX_WIDTH];
  // Invalidate targets the requesting set; word/tag writes target the fill set.
  assign wrIndex   = startFill ? rdIndex : fillIndex;

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : gWay
      icache_way #(
        .OFFSET_WIDTH(OFFSET_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
      ) uWay (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .rdIndex  (rdIndex),
        .rdTag    (rdTag),
        .rdOffset (rdOffset),
        .match    (wayMatch[w]),
        .lineValid(wayValid[w]),
        .rdData   (wayData[w]),
        .wrIndex  (wrIndex),
        .invEn    (startFill && (victimSel == 1'(w))),
        .wordEn   (wordWrite && (victim == 1'(w))),
        .wrOffset (counter),
        .wrData   (dataIn),
        .tagEn    (fillDone && (victim == 1'(w))),
        .wrTag    (fillTag)
      );
    end
  endgenerate

  assign hit     = |wayMatch;
  assign dataOut = wayMatch[1] ? wayData[1] : wayData[0];

  always_comb begin
    victimSel = lru[rdIndex];
    if (!wayValid[0])
      victimSel = 1'b0;
    else if (!wayValid[1])
      victimSel = 1'b1;
  end

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    memFlagNext = memFlag;
    addrOutNext = addrOut;
    startFill   = 1'b0;
    wordWrite   = 1'b0;
    fillDone    = 1'b0;
    if (readyIn) begin
      case (state)
        IDLE: begin
          if (readFlag && !hit) begin
            startFill   = 1'b1;
            counterNext = '0;
            addrOutNext = {addrIn[31:LO], {LO{1'b0}}};
            memFlagNext = 1'b1;
            stateNext   = REQ;
          end
        end
        REQ: begin
          if (validIn) begin
            wordWrite   = 1'b1;
            memFlagNext = 1'b0;
            if (counter == {OFFSET_WIDTH{1'b1}}) begin
              fillDone  = 1'b1;
              stateNext = IDLE;
            end else begin
              counterNext = counter + 1'b1;
              stateNext   = GAP;
            end
          end
        end
        GAP: begin
          addrOutNext = {fillLine, counter, 2'b00};
          memFlagNext = 1'b1;
          stateNext   = REQ;
        end
        default: begin
          stateNext   = IDLE;
          memFlagNext = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state    <= IDLE;
      counter  <= '0;
      memFlag  <= 1'b0;
      addrOut  <= '0;
      victim   <= 1'b0;
      fillLine <= '0;
      lru      <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      memFlag <= memFlagNext;
      addrOut <= addrOutNext;
      if (startFill) begin
        victim   <= victimSel;
        fillLine <= addrIn[31:LO];
      end
      if (readyIn && readFlag && hit)
        lru[rdIndex] <= ~wayMatch[1];
      // Later assignment wins, so a completing fill overrides a same-set hit.
      if (fillDone)
        lru[fillIndex] <= ~victim;
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: vector table for hit/data checks plus
// hand-written fill, stall, reset and LRU-collision sequences.
module tb_icache_2way;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, readFlag, validIn;
  logic [31:0] addrIn, dataIn;
  logic        hit, memFlag;
  logic [31:0] dataOut, addrOut;

  int errors = 0;
  int checks = 0;

  icache_2way dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .readyIn (readyIn),
    .readFlag(readFlag),
    .addrIn  (addrIn),
    .hit     (hit),
    .dataOut (dataOut),
    .memFlag (memFlag),
    .addrOut (addrOut),
    .validIn (validIn),
    .dataIn  (dataIn)
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        expHit;
    logic [31:0] expData;
  } vecT;

  vecT vecs[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  // Passive look-up: readFlag low so LRU is untouched.
  task automatic peek(input logic [31:0] a, input logic expHit);
    readFlag = 1'b0;
    addrIn   = a;
    #1;
    chk($sformatf("hit@%h", a), 32'(hit), 32'(expHit));
    if (expHit)
      chk($sformatf("data@%h", a), dataOut, memData(a));
  endtask

  task automatic startMiss(input logic [31:0] a);
    readFlag = 1'b1;
    addrIn   = a;
    #1;
    chk($sformatf("missHit@%h", a), 32'(hit), 32'd0);
    step();
    readFlag = 1'b0;
    chk("missMemFlag", 32'(memFlag), 32'd1);
    chk("missAddrOut", addrOut, {a[31:4], 4'h0});
  endtask

  // One-cycle controller latency, then a validIn pulse; optional same-cycle read.
  task automatic serveWord(input logic [31:0] expAddr, input logic last,
                           input logic probe, input logic [31:0] probeAddr);
    chk("reqMemFlag", 32'(memFlag), 32'd1);
    chk($sformatf("reqAddr@%h", expAddr), addrOut, expAddr);
    step();
    chk("holdMemFlag", 32'(memFlag), 32'd1);
    validIn = 1'b1;
    dataIn  = memData(expAddr);
    if (probe) begin
      readFlag = 1'b1;
      addrIn   = probeAddr;
      #1;
      chk("probeHit", 32'(hit), 32'd1);
    end
    step();
    validIn  = 1'b0;
    readFlag = 1'b0;
    chk("dropMemFlag", 32'(memFlag), 32'd0);
    if (!last) begin
      step();
      chk("gapMemFlag", 32'(memFlag), 32'd1);
      chk("gapAddrOut", addrOut, expAddr + 32'd4);
    end
  endtask

  task automatic fullFill(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    startMiss(a);
    for (int w = 0; w < 4; w++)
      serveWord(base + 32'(4 * w), w == 3, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetIn  = 1'b1;
    readyIn  = 1'b1;
    readFlag = 1'b0;
    validIn  = 1'b0;
    addrIn   = 32'h0;
    dataIn   = 32'h0;

    vecs.push_back('{1'b1, 32'h0000_0000, 1'b1, memData(32'h0000_0000)});
    vecs.push_back('{1'b1, 32'h0000_000C, 1'b1, memData(32'h0000_000C)});
    vecs.push_back('{1'b0, 32'h0000_0800, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0404, 1'b1, memData(32'h0000_0404)});
    vecs.push_back('{1'b1, 32'h0000_0108, 1'b1, memData(32'h0000_0108)});
    vecs.push_back('{1'b0, 32'h0000_0400, 1'b1, memData(32'h0000_0400)});
    vecs.push_back('{1'b1, 32'h0000_0002, 1'b1, memData(32'h0000_0000)});

    // Reset state
    step();
    step();
    chk("rstMemFlag", 32'(memFlag), 32'd0);
    chk("rstAddrOut", addrOut, 32'h0);
    resetIn = 1'b0;
    peek(32'h0000_0100, 1'b0);

    // Basic line fill, then hit on third word
    fullFill(32'h0000_0100);
    peek(32'h0000_0108, 1'b1);

    // Two lines in set 0, table of hits/misses ending with 0x000 most recent
    fullFill(32'h0000_0000);
    fullFill(32'h0000_0400);
    foreach (vecs[i]) begin
      readFlag = vecs[i].rd;
      addrIn   = vecs[i].addr;
      #1;
      chk($sformatf("vecHit[%0d]", i), 32'(hit), 32'(vecs[i].expHit));
      if (vecs[i].expHit)
        chk($sformatf("vecData[%0d]", i), dataOut, vecs[i].expData);
      step();
      readFlag = 1'b0;
      chk($sformatf("vecNoReq[%0d]", i), 32'(memFlag), 32'd0);
    end
    fullFill(32'h0000_0800);
    peek(32'h0000_0000, 1'b1);
    peek(32'h0000_0400, 1'b0);
    peek(32'h0000_0804, 1'b1);

    // Hits served and misses ignored during a fill
    startMiss(32'h0000_0200);
    serveWord(32'h0000_0200, 1'b0, 1'b0, 32'h0);
    readFlag = 1'b1;
    addrIn   = 32'h0000_0004;
    #1;
    chk("fillHit", 32'(hit), 32'd1);
    chk("fillHitData", dataOut, memData(32'h0000_0004));
    step();
    addrIn = 32'h0000_0600;
    #1;
    chk("fillMissHit", 32'(hit), 32'd0);
    step();
    readFlag = 1'b0;
    chk("fillMissMemFlag", 32'(memFlag), 32'd1);
    chk("fillMissAddrOut", addrOut, 32'h0000_0204);
    for (int w = 1; w < 4; w++)
      serveWord(32'h0000_0200 + 32'(4 * w), w == 3, 1'b0, 32'h0);
    peek(32'h0000_020C, 1'b1);
    peek(32'h0000_0600, 1'b0);
    chk("noSecondFill", 32'(memFlag), 32'd0);

    // Stall with validIn held: nothing may advance
    startMiss(32'h0000_0300);
    serveWord(32'h0000_0300, 1'b0, 1'b0, 32'h0);
    readyIn = 1'b0;
    validIn = 1'b1;
    dataIn  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stallMemFlag[%0d]", c), 32'(memFlag), 32'd1);
      chk($sformatf("stallAddrOut[%0d]", c), addrOut, 32'h0000_0304);
    end
    validIn = 1'b0;
    readyIn = 1'b1;
    for (int w = 1; w < 4; w++)
      serveWord(32'h0000_0300 + 32'(4 * w), w == 3, 1'b0, 32'h0);
    peek(32'h0000_0304, 1'b1);
    peek(32'h0000_0300, 1'b1);

    // Reset in the middle of a fill
    startMiss(32'h0000_0500);
    serveWord(32'h0000_0500, 1'b0, 1'b0, 32'h0);
    serveWord(32'h0000_0504, 1'b0, 1'b0, 32'h0);
    resetIn = 1'b1;
    step();
    resetIn = 1'b0;
    chk("abortMemFlag", 32'(memFlag), 32'd0);
    chk("abortAddrOut", addrOut, 32'h0);
    peek(32'h0000_0500, 1'b0);
    peek(32'h0000_0000, 1'b0);
    fullFill(32'h0000_0504);
    peek(32'h0000_0504, 1'b1);

    // Hit and fill completion on the same set in one cycle: fill's LRU wins,
    // so the next miss in set 0 evicts way 0 (0x000) and keeps 0x400.
    fullFill(32'h0000_0000);
    startMiss(32'h0000_0400);
    for (int w = 0; w < 4; w++)
      serveWord(32'h0000_0400 + 32'(4 * w), w == 3, w == 3, 32'h0000_0008);
    peek(32'h0000_0008, 1'b1);
    peek(32'h0000_0408, 1'b1);
    fullFill(32'h0000_0800);
    peek(32'h0000_0400, 1'b1);
    peek(32'h0000_0000, 1'b0);
    peek(32'h0000_080C, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
